spi_reg_peripheral: RTL and testbench
=====================================

Name: spi_reg_peripheral

Overview:
SPI peripheral (mode 0, CPOL=0/CPHA=0) that gives an external controller access to the PWM configuration registers. It sits beside pwm_peripheral in the top-level wrapper. It takes sclk/copi/ncs from dedicated inputs and drives the five configuration buses that pwm_peripheral consumes. It is the writer/reader end of the register interface that pwm_peripheral only consumes; it also supports register readback on cipo.

Parameters:
SYNC_STAGES, 2, synchronizer depth for sclk/copi/ncs (minimum 2)
NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
sclk  input  1  SPI clock from controller, asynchronous to clk
copi  input  1  SPI data from controller, asynchronous
ncs  input  1  SPI chip select, active-low, asynchronous
cipo  output  1  SPI readback data
cipo_oe  output  1  high while cipo is actively driven
en_reg_out_7_0  output  8  register 0x00
en_reg_out_15_8  output  8  register 0x01
en_reg_pwm_7_0  output  8  register 0x02
en_reg_pwm_15_8  output  8  register 0x03
pwm_duty_cycle  output  8  register 0x04
wr_strobe  output  1  one-cycle pulse when a write commits
frame_err  output  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high. On rst=1 at a clk edge:
  - all five registers go to 0x00;
  - cipo=0, cipo_oe=0, wr_strobe=0, frame_err=0;
  - synchronizers are forced to idle: sclk=0, ncs=1;
  - FSM goes to IDLE and bit counter to 0.
- Reset mid-frame: the frame is abandoned with no commit. Bits remaining until ncs rises are ignored.
- Synchronization: SYNC_STAGES flops per input. Edges are detected on synchronized sclk and ncs (previous vs current).
- Supported rate: sclk ≤ clk/8; each sclk level must hold ≥4 clk cycles. Faster sclk is unsupported.
- Frame format: exactly 16 bits, MSB first, sampled on sclk rising edges.
  - bit15: 1 = write, 0 = read;
  - bits14:8: 7-bit address;
  - bits7:0: write data (ignored for reads).
- FSM states:
  - IDLE: ncs high. A synchronized ncs falling edge clears the shift register and counter and moves to SHIFT.
  - SHIFT: each sclk rising edge shifts copi into shift_in[0], and bit_cnt increments, saturating at 17. A ncs rising edge moves to IDLE.
  - In both states a synchronized ncs rising edge is handled per the commit rules below.
- Commit on ncs rising edge:
  - Write commits only if bit_cnt==16, bit15=1 and address<NUM_REGS.
  - The register updates on the clk cycle after the detected ncs rise.
  - wr_strobe pulses high for that same cycle.
- Discards:
  - bit_cnt≠16 (short frame, or more than 16 bits) → no register change; frame_err pulses.
  - Address ≥ NUM_REGS → write ignored, no frame_err.
- Read path:
  - After the 8th rising edge, if bit15=0, load shift_out with the addressed register (0x00 if address ≥ NUM_REGS).
  - On the 8th sclk falling edge, drive cipo = shift_out[7] and assert cipo_oe.
  - Each subsequent falling edge shifts left.
  - cipo_oe drops, and cipo returns to 0, on the ncs rising edge or on the 16th falling edge, whichever comes first.
- Write frames: cipo_oe stays 0 throughout.
- Simultaneous events: an ncs rise and an sclk edge detected in the same clk cycle → ncs has priority; the sclk edge is ignored.
- ncs falling while in SHIFT (glitch): not possible without a rise first. Any ncs fall from IDLE restarts cleanly.
- Register outputs are flops, glitch-free, and hold their value between commits.

Decomposition:
- Package spi_reg_pkg:
  - address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_DUTY=0x04;
  - FRAME_BITS=16;
  - state typedef {IDLE, SHIFT}.
- Sub-module sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall detectors. Instanced for sclk and ncs; its synchronized output is also used for copi.

Test Plan:
1. Write 0x00 ← 0xA5 (frame 0x80A5, sclk=clk/10) → en_reg_out_7_0=0xA5 one cycle after the synchronized ncs rise; wr_strobe pulses once; other registers stay 0x00.
2. Write 0x04 ← 0x80, then read 0x04 (frame 0x0400) → pwm_duty_cycle=0x80; cipo shifts 1,0,0,0,0,0,0,0 on bits 8–15; cipo_oe high only during the data phase; register unchanged.
3. Short frame: ncs rises after 12 bits of 0x81FF → no register change; frame_err=1 for one cycle.
4. Long frame: 17 bits → discarded, frame_err pulses. Address 0x05 with 16 bits → no change, no frame_err, no wr_strobe.
5. Assert rst for one cycle during bit 10 of a write of 0x83FF, after writing 0xFF to 0x03 → all registers 0x00; no commit at the ncs rise; next valid frame works.
6. Back-to-back writes to 0x02 and 0x03 with ncs high for 6 clk → en_reg_pwm_7_0 and en_reg_pwm_15_8 both updated; two wr_strobe pulses.

Source files
------------

// File: rtl/spi_reg_peripheral_pkg.sv
// Shared constants and FSM state encoding for the SPI register peripheral.
package spi_reg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int FRAME_BITS = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between an external controller (master) and the register peripheral (slave).
interface spi_reg_peripheral_if;
  // Mode 0 framing, no valid/ready: ncs low brackets a frame, copi is sampled on
  // sclk rise, cipo changes on sclk fall and is meaningful only while cipo_oe is high.
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus rise/fall detection.
module sync_edge
  import spi_reg_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   vld_q, vld_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
    vld_d  = {vld_q[STAGES-1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end

  // Edges stay masked until both current and previous samples come from the pin,
  // so a line that is not idle when reset releases does not fake an edge.
  assign q    = sync_q[STAGES-1];
  assign rise = vld_q[STAGES] &  q & ~prev_q;
  assign fall = vld_q[STAGES] & ~q &  prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 register peripheral: 16-bit frames write or read the PWM configuration registers.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_peripheral_if.slave  spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 wr_strobe,
  output logic                 frame_err,
  output state_t               dbg_state
);

  typedef logic [NUM_REGS-1:0][7:0] regfile_t;

  function automatic logic [7:0] reg_at(input regfile_t regs, input logic [6:0] addr);
    logic [7:0] val;
    val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 7'(i)) val = regs[i];
    end
    return val;
  endfunction

  logic sclk_s, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise, copi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi.sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(spi.ncs), .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(spi.copi), .q(copi_s), .rise(copi_rise), .fall(copi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, ncs_s, copi_rise, copi_fall};

  state_t     state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_in_q, shift_in_d;
  logic [7:0] shift_out_q, shift_out_d;
  logic       rd_q, rd_d;
  logic       cipo_q, cipo_d;
  logic       cipo_oe_q, cipo_oe_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       frame_err_q, frame_err_d;
  regfile_t   regs_q, regs_d;

  logic [15:0] new_word;
  logic [6:0]  wr_addr;
  logic        hit;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    rd_d        = rd_q;
    cipo_d      = cipo_q;
    cipo_oe_d   = cipo_oe_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    hit         = 1'b0;
    new_word    = {shift_in_q[14:0], copi_s};
    wr_addr     = shift_in_q[14:8];

    // ncs rise wins over any sclk edge seen in the same cycle.
    if (ncs_rise) begin
      state_d   = IDLE;
      rd_d      = 1'b0;
      cipo_d    = 1'b0;
      cipo_oe_d = 1'b0;
      if (state_q == SHIFT) begin
        if (bit_cnt_q != 5'(FRAME_BITS)) begin
          frame_err_d = 1'b1;
        end else if (shift_in_q[15]) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == 7'(i)) begin
              regs_d[i] = shift_in_q[7:0];
              hit       = 1'b1;
            end
          end
          wr_strobe_d = hit;
        end
      end
    end else if (state_q == IDLE) begin
      if (ncs_fall) begin
        state_d    = SHIFT;
        shift_in_d = '0;
        bit_cnt_d  = '0;
        rd_d       = 1'b0;
      end
    end else if (sclk_rise) begin
      shift_in_d = new_word;
      if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
      // Eighth bit just landed: command and address are complete.
      if (bit_cnt_q == 5'd7 && !new_word[7]) begin
        rd_d        = 1'b1;
        shift_out_d = reg_at(regs_q, new_word[6:0]);
      end
    end else if (sclk_fall) begin
      if (rd_q && bit_cnt_q == 5'd8) begin
        cipo_oe_d   = 1'b1;
        cipo_d      = shift_out_q[7];
        shift_out_d = {shift_out_q[6:0], 1'b0};
      end else if (cipo_oe_q) begin
        if (bit_cnt_q >= 5'(FRAME_BITS)) begin
          cipo_oe_d = 1'b0;
          cipo_d    = 1'b0;
        end else begin
          cipo_d      = shift_out_q[7];
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      rd_q        <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      rd_q        <= rd_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  assign spi.cipo        = cipo_q;
  assign spi.cipo_oe     = cipo_oe_q;
  assign wr_strobe       = wr_strobe_q;
  assign frame_err       = frame_err_q;
  assign dbg_state       = state_q;
  assign en_reg_out_7_0  = reg_at(regs_q, ADDR_EN_OUT_LO);
  assign en_reg_out_15_8 = reg_at(regs_q, ADDR_EN_OUT_HI);
  assign en_reg_pwm_7_0  = reg_at(regs_q, ADDR_EN_PWM_LO);
  assign en_reg_pwm_15_8 = reg_at(regs_q, ADDR_EN_PWM_HI);
  assign pwm_duty_cycle  = reg_at(regs_q, ADDR_DUTY);

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed and randomized frames against spi_reg_peripheral with a register model and readback queue.
module tb_spi_reg_peripheral;
  import spi_reg_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_peripheral_if bus();

  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe, frame_err;
  state_t     dbg_state;

  spi_reg_peripheral #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk), .rst(rst), .spi(bus.slave),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl [5];
  int strobe_cycles = 0, strobe_pulses = 0, err_cycles = 0, err_pulses = 0, bad_change = 0;
  logic strobe_prev = 1'b0, err_prev = 1'b0, rst_at_edge = 1'b1;
  logic [39:0] regs_prev = '0;
  int oe_bad = 0;
  logic [7:0] rd_bits = '0;

  always @(posedge clk) rst_at_edge = rst;

  always @(negedge clk) begin
    logic [39:0] cur;
    cur = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
    if (wr_strobe) strobe_cycles++;
    if (wr_strobe && !strobe_prev) strobe_pulses++;
    if (frame_err) err_cycles++;
    if (frame_err && !err_prev) err_pulses++;
    if (cur !== regs_prev && !wr_strobe && !rst_at_edge) bad_change++;
    regs_prev   = cur;
    strobe_prev = wr_strobe;
    err_prev    = frame_err;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver: one frame, MSB first, sclk = clk/10; rst_bit >= 0 pulses rst during that bit
  task automatic spi_frame(input logic [31:0] word, input int nbits, input int rst_bit, input int gap);
    logic is_read, exp_oe;
    is_read = (nbits >= 8) && !word[nbits-1];
    oe_bad  = 0;
    rd_bits = '0;
    bus.ncs = 1'b0;
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      bus.copi = word[nbits-1-i];
      if (i == rst_bit) begin
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(4);
      end else begin
        wait_clk(5);
      end
      if (rst_bit < 0) begin
        exp_oe = is_read && (i >= 8) && (i < 16);
        if (bus.cipo_oe !== exp_oe) oe_bad++;
        if (i >= 8 && i < 16) rd_bits = {rd_bits[6:0], bus.cipo};
      end
      bus.sclk = 1'b1;
      wait_clk(5);
      bus.sclk = 1'b0;
    end
    wait_clk(5);
    if (rst_bit < 0 && bus.cipo_oe !== 1'b0) oe_bad++;
    bus.ncs = 1'b1;
    wait_clk(gap);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_r0"}, 32'(en_reg_out_7_0),  32'(mdl[0]));
    check({tag, "_r1"}, 32'(en_reg_out_15_8), 32'(mdl[1]));
    check({tag, "_r2"}, 32'(en_reg_pwm_7_0),  32'(mdl[2]));
    check({tag, "_r3"}, 32'(en_reg_pwm_15_8), 32'(mdl[3]));
    check({tag, "_r4"}, 32'(pwm_duty_cycle),  32'(mdl[4]));
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [7:0] data, input string tag);
    int s0, c0, e0;
    s0 = strobe_pulses; c0 = strobe_cycles; e0 = err_pulses;
    spi_frame({16'h0, 1'b1, addr, data}, 16, -1, 10);
    if (addr < 7'd5) mdl[addr[2:0]] = data;
    check({tag, "_strobe"}, 32'(strobe_pulses - s0), (addr < 7'd5) ? 32'd1 : 32'd0);
    check({tag, "_strobe_w"}, 32'(strobe_cycles - c0), (addr < 7'd5) ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(err_pulses - e0), 32'd0);
    check({tag, "_oe"}, 32'(oe_bad), 32'd0);
    check_regs(tag);
  endtask

  task automatic do_read(input logic [6:0] addr, input string tag);
    int s0;
    logic [7:0] exp;
    s0 = strobe_pulses;
    exp_q.push_back((addr < 7'd5) ? mdl[addr[2:0]] : 8'h00);
    spi_frame({16'h0, 1'b0, addr, 8'h00}, 16, -1, 10);
    exp = exp_q.pop_front();
    check({tag, "_data"}, 32'(rd_bits), 32'(exp));
    check({tag, "_oe"}, 32'(oe_bad), 32'd0);
    check({tag, "_strobe"}, 32'(strobe_pulses - s0), 32'd0);
    check_regs(tag);
  endtask

  initial begin
    int s0, e0, c0;
    logic [6:0] ra;
    logic [7:0] rdat;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);

    check_regs("reset");
    check("reset_cipo", 32'(bus.cipo), 32'd0);
    check("reset_cipo_oe", 32'(bus.cipo_oe), 32'd0);
    check("reset_strobe", 32'(wr_strobe), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    do_write(7'h00, 8'hA5, "wr0");
    do_write(7'h04, 8'h80, "wr4");
    do_read(7'h04, "rd4");
    do_read(7'h00, "rd0");

    // short frame: first 12 bits of 0x81FF
    s0 = strobe_pulses; e0 = err_pulses; c0 = err_cycles;
    spi_frame(32'h0000_081F, 12, -1, 10);
    check("short_err", 32'(err_pulses - e0), 32'd1);
    check("short_err_w", 32'(err_cycles - c0), 32'd1);
    check("short_strobe", 32'(strobe_pulses - s0), 32'd0);
    check_regs("short");

    // long frame: 17 bits
    s0 = strobe_pulses; e0 = err_pulses;
    spi_frame(32'h0001_0223, 17, -1, 10);
    check("long_err", 32'(err_pulses - e0), 32'd1);
    check("long_strobe", 32'(strobe_pulses - s0), 32'd0);
    check_regs("long");

    do_write(7'h05, 8'h33, "wr5");
    do_read(7'h05, "rd5");

    // reset during bit 10 of a write after loading register 3
    do_write(7'h03, 8'hFF, "wr3");
    s0 = strobe_pulses;
    spi_frame(32'h0000_83FF, 16, 10, 10);
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    check("rstmid_strobe", 32'(strobe_pulses - s0), 32'd0);
    check("rstmid_state", 32'(dbg_state), 32'(IDLE));
    check_regs("rstmid");
    do_write(7'h01, 8'h42, "wr1");

    // back-to-back writes with ncs high for 6 clk
    s0 = strobe_pulses;
    spi_frame(32'h0000_8211, 16, -1, 6);
    spi_frame(32'h0000_8322, 16, -1, 10);
    mdl[2] = 8'h11;
    mdl[3] = 8'h22;
    check("b2b_strobe", 32'(strobe_pulses - s0), 32'd2);
    check_regs("b2b");

    for (int n = 0; n < 3; n++) begin
      ra   = 7'($urandom_range(0, 4));
      rdat = 8'($urandom_range(0, 255));
      do_write(ra, rdat, "rnd_wr");
      do_read(ra, "rnd_rd");
    end

    check("reg_change_no_strobe", 32'(bad_change), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_state", 32'(dbg_state), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
